memory_arbiter: RTL and testbench

Arbitrates the shared backing memory between the instruction cache refill path (L1I) and the data cache read/write path (L1D). Sits between the two `l1` instances and the single-port main memory, replacing the combinational sharing in `memory_controller`. It serialises one transaction at a time with a req/ack handshake toward memory. It also drives the `stall_l1i`/`stall_l1d` levels the pipeline already consumes.

---
 rtl/memory_arbiter.sv | 126 ++++++++++++
 tb/tb_memory_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// ============================================================================
// memory_arbiter : serialises L1I refills and L1D accesses onto one
//                  single-port memory with a req/ack handshake.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module memory_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        l1i_req,
  input  logic [31:0] l1i_addr,
  output logic        l1i_done,
  output logic        stall_l1i,
  input  logic        l1d_req,
  input  logic        l1d_we,
  input  logic [31:0] l1d_addr,
  input  logic [31:0] l1d_wdata,
  output logic        l1d_done,
  output logic        stall_l1d,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_BUSY = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  localparam logic [3:0] c_STARVE_LIMIT = STARVE_LIMIT[3:0];
  localparam logic [3:0] c_STARVE_MAX   = 4'hF;

  logic [1:0]  r_state;
  logic        r_owner;
  logic [3:0]  r_starve_cnt;
  logic [31:0] r_rdata;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;

  logic        w_any_req;
  logic        w_grant_d;
  logic        w_done_cycle;

  assign w_any_req    = l1i_req | l1d_req;
  // L1D wins ties until L1I has watched STARVE_LIMIT L1D grants go by.
  assign w_grant_d    = l1d_req & (~l1i_req | (r_starve_cnt != c_STARVE_LIMIT));
  assign w_done_cycle = (r_state == c_ST_DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= c_ST_IDLE;
      r_owner      <= 1'b0;
      r_starve_cnt <= 4'd0;
      r_rdata      <= 32'd0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_wdata  <= 32'd0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_any_req) begin
            r_state   <= c_ST_BUSY;
            r_mem_req <= 1'b1;
            r_owner   <= w_grant_d;
            if (w_grant_d) begin
              r_mem_addr  <= l1d_addr;
              r_mem_we    <= l1d_we;
              r_mem_wdata <= l1d_wdata;
              if (l1i_req) begin
                if (r_starve_cnt != c_STARVE_MAX) begin
                  r_starve_cnt <= r_starve_cnt + 4'd1;
                end
              end else begin
                r_starve_cnt <= 4'd0;
              end
            end else begin
              r_mem_addr   <= l1i_addr;
              r_mem_we     <= 1'b0;
              r_mem_wdata  <= 32'd0;
              r_starve_cnt <= 4'd0;
            end
          end
        end
        c_ST_BUSY: begin
          if (mem_ack) begin
            r_state   <= c_ST_DONE;
            r_mem_req <= 1'b0;
            if (!r_mem_we) begin
              r_rdata <= mem_rdata;
            end
          end
        end
        c_ST_DONE: begin
          r_state <= c_ST_IDLE;
        end
        default: begin
          r_state   <= c_ST_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign l1i_done  = w_done_cycle & ~r_owner;
  assign l1d_done  = w_done_cycle &  r_owner;
  assign stall_l1i = l1i_req & ~l1i_done;
  assign stall_l1d = l1d_req & ~l1d_done;

  assign rdata     = r_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_memory_arbiter.sv
// ============================================================================
// tb_memory_arbiter : directed self-checking bench for memory_arbiter.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_memory_arbiter;

  logic        clock;
  logic        reset_n;
  logic        l1i_req;
  logic [31:0] l1i_addr;
  logic        l1i_done;
  logic        stall_l1i;
  logic        l1d_req;
  logic        l1d_we;
  logic [31:0] l1d_addr;
  logic [31:0] l1d_wdata;
  logic        l1d_done;
  logic        stall_l1d;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        auto_ack;
  logic        man_ack;
  logic [31:0] man_rdata;

  int checks;
  int errors;

  // Auto responder acks in the first BUSY cycle (mem_req is high only in BUSY).
  assign mem_ack   = auto_ack ? mem_req : man_ack;
  assign mem_rdata = auto_ack ? ~mem_addr : man_rdata;

  memory_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .l1i_req   (l1i_req),
    .l1i_addr  (l1i_addr),
    .l1i_done  (l1i_done),
    .stall_l1i (stall_l1i),
    .l1d_req   (l1d_req),
    .l1d_we    (l1d_we),
    .l1d_addr  (l1d_addr),
    .l1d_wdata (l1d_wdata),
    .l1d_done  (l1d_done),
    .stall_l1d (stall_l1d),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #3;
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'd0 || rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: mem_req=%b mem_we=%b mem_addr=%h rdata=%h, required all 0",
               mem_req, mem_we, mem_addr, rdata);
    end
    tick;
    tick;
    reset_n = 1'b1;
    tick;
    tick;
    checks++;
    if (mem_req !== 1'b0 || l1i_done !== 1'b0 || l1d_done !== 1'b0 || stall_l1i !== 1'b0 || stall_l1d !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: mem_req=%b l1i_done=%b l1d_done=%b stall_i=%b stall_d=%b, required 0",
               mem_req, l1i_done, l1d_done, stall_l1i, stall_l1d);
    end
  endtask

  task automatic test_l1i_read;
    l1i_req  = 1'b1;
    l1i_addr = 32'h10;
    #1;
    checks++;
    if (stall_l1i !== 1'b1) begin
      errors++;
      $display("FAIL l1i_stall_c0: got %b required 1", stall_l1i);
    end
    tick;  // cycle 1: BUSY
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0 || mem_wdata !== 32'd0 || l1i_done !== 1'b0) begin
      errors++;
      $display("FAIL l1i_busy: mem_req=%b addr=%h we=%b wdata=%h done=%b, required 1 00000010 0 0 0",
               mem_req, mem_addr, mem_we, mem_wdata, l1i_done);
    end
    man_ack   = 1'b1;
    man_rdata = 32'hDEADBEEF;
    tick;  // cycle 2: DONE
    man_ack = 1'b0;
    checks++;
    if (l1i_done !== 1'b1 || l1d_done !== 1'b0 || stall_l1i !== 1'b0 || rdata !== 32'hDEADBEEF || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL l1i_done: done=%b d_done=%b stall=%b rdata=%h mem_req=%b, required 1 0 0 deadbeef 0",
               l1i_done, l1d_done, stall_l1i, rdata, mem_req);
    end
    tick;
    l1i_req = 1'b0;
    #1;
    checks++;
    if (l1i_done !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL l1i_single_pulse: done=%b mem_req=%b, required 0 0", l1i_done, mem_req);
    end
  endtask

  task automatic test_l1d_write;
    l1d_req   = 1'b1;
    l1d_we    = 1'b1;
    l1d_addr  = 32'h200;
    l1d_wdata = 32'h12345678;
    tick;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'h12345678 || l1d_done !== 1'b0 || stall_l1d !== 1'b1) begin
        errors++;
        $display("FAIL l1d_wr_busy%0d: req=%b we=%b addr=%h wdata=%h done=%b stall=%b, required 1 1 00000200 12345678 0 1",
                 c, mem_req, mem_we, mem_addr, mem_wdata, l1d_done, stall_l1d);
      end
      if (c == 2) begin
        man_ack   = 1'b1;
        man_rdata = 32'hBAD0BAD0;
      end
      tick;
    end
    man_ack = 1'b0;
    checks++;
    if (l1d_done !== 1'b1 || l1i_done !== 1'b0 || rdata !== 32'hDEADBEEF || stall_l1d !== 1'b0) begin
      errors++;
      $display("FAIL l1d_wr_done: done=%b i_done=%b rdata=%h stall=%b, required 1 0 deadbeef 0",
               l1d_done, l1i_done, rdata, stall_l1d);
    end
    tick;
    l1d_req = 1'b0;
    l1d_we  = 1'b0;
  endtask

  task automatic test_spurious_ack;
    man_ack = 1'b1;
    man_rdata = 32'h77777777;
    tick;
    tick;
    checks++;
    if (mem_req !== 1'b0 || l1i_done !== 1'b0 || l1d_done !== 1'b0 || rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL spurious_idle: mem_req=%b i_done=%b d_done=%b rdata=%h, required 0 0 0 deadbeef",
               mem_req, l1i_done, l1d_done, rdata);
    end
    man_ack  = 1'b0;
    l1i_req  = 1'b1;
    l1i_addr = 32'h20;
    tick;  // BUSY
    man_ack   = 1'b1;
    man_rdata = 32'hCAFEF00D;
    tick;  // DONE, ack stays high
    man_rdata = 32'h11111111;
    checks++;
    if (l1i_done !== 1'b1 || rdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL spurious_done_cycle: done=%b rdata=%h, required 1 cafef00d", l1i_done, rdata);
    end
    tick;  // IDLE
    l1i_req = 1'b0;
    #1;
    checks++;
    if (l1i_done !== 1'b0 || mem_req !== 1'b0 || rdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL spurious_after_done: done=%b mem_req=%b rdata=%h, required 0 0 cafef00d",
               l1i_done, mem_req, rdata);
    end
    tick;
    man_ack = 1'b0;
    tick;
    checks++;
    if (mem_req !== 1'b0 || l1i_done !== 1'b0 || l1d_done !== 1'b0) begin
      errors++;
      $display("FAIL spurious_settle: mem_req=%b i_done=%b d_done=%b, required 0 0 0",
               mem_req, l1i_done, l1d_done);
    end
  endtask

  task automatic test_drop_mid_busy;
    l1d_req  = 1'b1;
    l1d_we   = 1'b0;
    l1d_addr = 32'h300;
    l1i_req  = 1'b1;
    l1i_addr = 32'h40;
    tick;  // BUSY for L1D (tie goes to L1D with starve_cnt 0)
    checks++;
    if (mem_addr !== 32'h300 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL drop_grant_d: addr=%h req=%b, required 00000300 1", mem_addr, mem_req);
    end
    l1d_req = 1'b0;
    tick;
    man_ack   = 1'b1;
    man_rdata = 32'h55AA55AA;
    tick;  // DONE
    man_ack = 1'b0;
    checks++;
    if (l1d_done !== 1'b1 || l1i_done !== 1'b0 || rdata !== 32'h55AA55AA) begin
      errors++;
      $display("FAIL drop_done: d_done=%b i_done=%b rdata=%h, required 1 0 55aa55aa",
               l1d_done, l1i_done, rdata);
    end
    tick;  // IDLE, L1I granted at next edge
    tick;  // BUSY for L1I
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL drop_then_l1i: req=%b addr=%h we=%b, required 1 00000040 0", mem_req, mem_addr, mem_we);
    end
    man_ack   = 1'b1;
    man_rdata = 32'h0BADF00D;
    tick;
    man_ack = 1'b0;
    checks++;
    if (l1i_done !== 1'b1 || rdata !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL drop_l1i_done: done=%b rdata=%h, required 1 0badf00d", l1i_done, rdata);
    end
    tick;
    l1i_req = 1'b0;
  endtask

  task automatic test_starvation;
    string seen;
    string expect_seq;
    int    cyc;
    seen       = "";
    expect_seq = "DDDDID";
    auto_ack   = 1'b1;
    l1i_req    = 1'b1;
    l1i_addr   = 32'h100;
    l1d_req    = 1'b1;
    l1d_we     = 1'b0;
    l1d_addr   = 32'h500;
    cyc        = 0;
    while (seen.len() < 6 && cyc < 60) begin
      tick;
      cyc++;
      if (l1i_done === 1'b1 && l1d_done === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL starve_both_done: both done pulses high together");
      end
      if (l1d_done === 1'b1) begin
        seen = {seen, "D"};
        checks++;
        if (rdata !== ~32'h500) begin
          errors++;
          $display("FAIL starve_d_rdata: got %h required %h", rdata, ~32'h500);
        end
      end
      if (l1i_done === 1'b1) begin
        seen = {seen, "I"};
        tick;
        cyc++;
        l1i_req = 1'b0;
      end
    end
    checks++;
    if (seen.len() < 6) begin
      errors++;
      $display("FAIL starve_timeout: only %0d grants seen (%s), required 6", seen.len(), seen);
    end else begin
      for (int g = 0; g < 6; g++) begin
        checks++;
        if (seen[g] != expect_seq[g]) begin
          errors++;
          $display("FAIL starve_order%0d: got %s required %s (sequence %s)",
                   g, string'(seen[g]), string'(expect_seq[g]), seen);
        end
      end
    end
    l1d_req = 1'b0;
    for (int w = 0; w < 4; w++) tick;
    auto_ack = 1'b0;
  endtask

  task automatic test_reset_mid_busy;
    l1d_req  = 1'b1;
    l1d_we   = 1'b0;
    l1d_addr = 32'h400;
    tick;
    checks++;
    if (mem_req !== 1'b1 || rdata === 32'd0) begin
      errors++;
      $display("FAIL rst_pre_busy: mem_req=%b rdata=%h, required 1 and nonzero", mem_req, rdata);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || rdata !== 32'd0 || mem_addr !== 32'd0 || l1d_done !== 1'b0 || stall_l1d !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_busy: mem_req=%b rdata=%h addr=%h done=%b stall_d=%b, required 0 0 0 0 1",
               mem_req, rdata, mem_addr, l1d_done, stall_l1d);
    end
    l1d_req = 1'b0;
    #1;
    checks++;
    if (stall_l1d !== 1'b0) begin
      errors++;
      $display("FAIL rst_stall_follow: stall_d=%b required 0", stall_l1d);
    end
    tick;
    #2;
    reset_n = 1'b1;
    for (int w = 0; w < 3; w++) begin
      tick;
      checks++;
      if (mem_req !== 1'b0 || l1i_done !== 1'b0 || l1d_done !== 1'b0 || rdata !== 32'd0) begin
        errors++;
        $display("FAIL rst_after_release%0d: mem_req=%b i_done=%b d_done=%b rdata=%h, required 0 0 0 0",
                 w, mem_req, l1i_done, l1d_done, rdata);
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    l1i_req   = 1'b0;
    l1i_addr  = 32'd0;
    l1d_req   = 1'b0;
    l1d_we    = 1'b0;
    l1d_addr  = 32'd0;
    l1d_wdata = 32'd0;
    auto_ack  = 1'b0;
    man_ack   = 1'b0;
    man_rdata = 32'd0;
    test_reset;
    test_l1i_read;
    test_l1d_write;
    test_spurious_ack;
    test_drop_mid_busy;
    test_starvation;
    test_reset_mid_busy;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
